// File: rtl/rx_frame_writer_if.sv
// rtl/rx_frame_writer_if.sv - RX byte stream, RAM port A and status bundle for rx_frame_writer
interface rx_frame_writer_if #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 9
) ();
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_sop;
    logic                  in_eop;
    logic                  in_err;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_wren;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [ADDR_WIDTH-1:0] commit_ptr;
    logic                  frame_ok;
    logic                  frame_drop;
    logic [15:0]           drop_cnt;

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_err, rd_ptr,
        input  ram_data, ram_wren, ram_addr, commit_ptr, frame_ok, frame_drop, drop_cnt
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_err, rd_ptr,
        output ram_data, ram_wren, ram_addr, commit_ptr, frame_ok, frame_drop, drop_cnt
    );
endinterface

// File: rtl/rx_frame_writer.sv
// rtl/rx_frame_writer.sv - packs RX bytes into 36-bit frame-buffer words, commits only complete good frames
module rx_frame_writer #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 9
) (
    input  logic            clk,
    input  logic            rst,
    rx_frame_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = 1;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nx;
    logic [1:0]            idx, idx_nx;
    logic [31:0]           pack, pack_nx;
    logic                  sop_flag, sop_nx;
    logic [ADDR_WIDTH-1:0] commit_q, commit_hold;
    logic                  commit_pend, commit_set;
    logic [DATA_WIDTH-1:0] data_q, data_nx;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
    logic                  wren_q, wren_nx;
    logic                  ok_q, drop_q;
    logic [15:0]           drop_cnt_q;

    logic                  start, drop_old, drop_new;
    logic [ADDR_WIDTH-1:0] eff_commit, base_ptr, next_addr;
    logic [1:0]            base_idx;
    logic [31:0]           lanes;
    logic                  base_sop, space;
    logic [1:0]            drop_inc;
    logic [16:0]           drop_sum;

    always_comb begin
        // A commit that is one cycle from being published is already the rewind target.
        eff_commit = commit_pend ? commit_hold : commit_q;
        start      = bus.in_valid & bus.in_sop;
        base_ptr   = start ? eff_commit : wr_ptr;
        base_idx   = start ? 2'd0 : idx;
        lanes      = start ? 32'd0 : pack;
        lanes[{base_idx, 3'b000} +: 8] = bus.in_data;
        base_sop   = start | sop_flag;
        next_addr  = base_ptr + ONE;
        space      = (next_addr != bus.rd_ptr);

        state_nx   = state;
        wr_ptr_nx  = wr_ptr;
        idx_nx     = idx;
        pack_nx    = pack;
        sop_nx     = sop_flag;
        wren_nx    = 1'b0;
        data_nx    = data_q;
        addr_nx    = addr_q;
        commit_set = 1'b0;
        drop_old   = start & (state == RECV);
        drop_new   = 1'b0;

        if (bus.in_valid & (start | (state == RECV))) begin
            if (bus.in_eop & bus.in_err) begin
                drop_new  = 1'b1;
                wr_ptr_nx = eff_commit;
                idx_nx    = 2'd0;
                pack_nx   = 32'd0;
                sop_nx    = 1'b0;
                state_nx  = IDLE;
            end else if (bus.in_eop | (base_idx == 2'd3)) begin
                idx_nx  = 2'd0;
                pack_nx = 32'd0;
                sop_nx  = 1'b0;
                if (space) begin
                    wren_nx   = 1'b1;
                    addr_nx   = base_ptr;
                    data_nx   = {(bus.in_eop ? base_idx : 2'd0), bus.in_eop, base_sop, lanes};
                    wr_ptr_nx = next_addr;
                    if (bus.in_eop) begin
                        commit_set = 1'b1;
                        state_nx   = IDLE;
                    end else begin
                        state_nx = RECV;
                    end
                end else begin
                    drop_new  = 1'b1;
                    wr_ptr_nx = eff_commit;
                    state_nx  = bus.in_eop ? IDLE : DROP;
                end
            end else begin
                wr_ptr_nx = base_ptr;
                idx_nx    = base_idx + 2'd1;
                pack_nx   = lanes;
                sop_nx    = base_sop;
                state_nx  = RECV;
            end
        end else if ((state == DROP) & bus.in_valid & bus.in_eop) begin
            state_nx = IDLE;
        end

        drop_inc = {1'b0, drop_old} + {1'b0, drop_new};
        drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            idx         <= 2'd0;
            pack        <= 32'd0;
            sop_flag    <= 1'b0;
            commit_q    <= '0;
            commit_hold <= '0;
            commit_pend <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
            wren_q      <= 1'b0;
            ok_q        <= 1'b0;
            drop_q      <= 1'b0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state       <= state_nx;
            wr_ptr      <= wr_ptr_nx;
            idx         <= idx_nx;
            pack        <= pack_nx;
            sop_flag    <= sop_nx;
            data_q      <= data_nx;
            addr_q      <= addr_nx;
            wren_q      <= wren_nx;
            // Publish one edge after the EOP word is presented, i.e. as the RAM absorbs it.
            commit_pend <= commit_set;
            if (commit_set)
                commit_hold <= next_addr;
            if (commit_pend)
                commit_q <= commit_hold;
            ok_q        <= commit_pend;
            drop_q      <= (drop_inc != 2'd0);
            drop_cnt_q  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign bus.ram_data   = data_q;
    assign bus.ram_wren   = wren_q;
    assign bus.ram_addr   = addr_q;
    assign bus.commit_ptr = commit_q;
    assign bus.frame_ok   = ok_q;
    assign bus.frame_drop = drop_q;
    assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_rx_frame_writer.sv
// tb/tb_rx_frame_writer.sv - scoreboard bench for rx_frame_writer
module tb_rx_frame_writer;
    localparam int AW = 9;
    localparam int DW = 36;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_frame_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    rx_frame_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        bit          is_drop;
        logic [15:0] val;
    } ev_t;

    wr_t exp_wr[$];
    ev_t exp_ev[$];
    int  errors = 0;
    int  checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        wr_t w;
        ev_t e;
        if (!rst) begin
            if (bus.ram_wren) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write_addr", {55'd0, bus.ram_addr}, 64'hFFFF);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", {55'd0, bus.ram_addr}, {55'd0, w.addr});
                    check("wr_data", {28'd0, bus.ram_data}, {28'd0, w.data});
                end
            end
            if (bus.frame_ok) begin
                if (exp_ev.size() == 0) begin
                    check("unexpected_frame_ok", 64'd1, 64'd0);
                end else begin
                    e = exp_ev.pop_front();
                    check("ok_kind", {63'd0, e.is_drop}, 64'd0);
                    check("commit_ptr", {55'd0, bus.commit_ptr}, {48'd0, e.val});
                end
            end
            if (bus.frame_drop) begin
                if (exp_ev.size() == 0) begin
                    check("unexpected_frame_drop", 64'd1, 64'd0);
                end else begin
                    e = exp_ev.pop_front();
                    check("drop_kind", {63'd0, e.is_drop}, 64'd1);
                    check("drop_cnt", {48'd0, bus.drop_cnt}, {48'd0, e.val});
                end
            end
        end
    end

    task automatic push_wr(input int addr, input logic [35:0] data);
        wr_t w;
        w.addr = AW'(addr);
        w.data = data;
        exp_wr.push_back(w);
    endtask

    task automatic push_ev(input bit is_drop, input int val);
        ev_t e;
        e.is_drop = is_drop;
        e.val     = 16'(val);
        exp_ev.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input logic sop, input logic eop, input logic err);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        bus.in_err   = err;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.rd_ptr = '0;
        idle(2);
        @(negedge clk);
        check("rst_wren", {63'd0, bus.ram_wren}, 64'd0);
        check("rst_commit", {55'd0, bus.commit_ptr}, 64'd0);
        check("rst_flags", {62'd0, bus.frame_ok, bus.frame_drop}, 64'd0);
        check("rst_drop_cnt", {48'd0, bus.drop_cnt}, 64'd0);
        check("rst_data_addr", {19'd0, bus.ram_data, bus.ram_addr}, 64'd0);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic drain(input string name, input int commit);
        idle(5);
        check({name, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
        check({name, "_ev_left"}, 64'(exp_ev.size()), 64'd0);
        check({name, "_commit"}, {55'd0, bus.commit_ptr}, 64'(commit));
    endtask

    initial begin
        logic [7:0] b;
        logic [3:0] fl;
        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_err   = 1'b0;
        bus.rd_ptr   = '0;

        // Good 6-byte frame
        do_reset();
        push_wr(0, 36'h1_04030201);
        push_wr(1, 36'h6_00000605);
        push_ev(0, 2);
        for (int i = 1; i <= 6; i++) send(8'(i), i == 1, i == 6, 1'b0);
        drain("six_byte", 2);

        // Single-byte frame with latency checks
        do_reset();
        push_wr(0, 36'h3_000000AA);
        push_ev(0, 1);
        send(8'hAA, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("single_wren_n1", {63'd0, bus.ram_wren}, 64'd1);
        check("single_ok_n1", {63'd0, bus.frame_ok}, 64'd0);
        check("single_commit_n1", {55'd0, bus.commit_ptr}, 64'd0);
        @(negedge clk);
        check("single_ok_n2", {63'd0, bus.frame_ok}, 64'd1);
        drain("single", 1);

        // Errored 9-byte frame, then good frame reuses addr0
        do_reset();
        push_wr(0, 36'h1_13121110);
        push_wr(1, 36'h0_17161514);
        push_ev(1, 1);
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), i == 0, i == 8, i == 8);
        @(negedge clk);
        check("err_drop_n1", {63'd0, bus.frame_drop}, 64'd1);
        drain("err_frame", 0);
        push_wr(0, 36'h7_00002221);
        push_ev(0, 1);
        send(8'h21, 1'b1, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b1, 1'b0);
        drain("after_err", 1);

        // Buffer full: third word blocked by rd_ptr=3
        do_reset();
        bus.rd_ptr = 9'd3;
        push_wr(0, 36'h1_33323130);
        push_wr(1, 36'h0_37363534);
        push_ev(1, 1);
        for (int i = 0; i < 20; i++) send(8'h30 + 8'(i), i == 0, i == 19, 1'b0);
        drain("full", 0);
        check("full_drop_cnt", {48'd0, bus.drop_cnt}, 64'd1);

        // SOP mid-frame abandons the partial frame
        do_reset();
        push_wr(0, 36'h1_53525150);
        push_ev(1, 1);
        push_wr(0, 36'h1_63626160);
        push_wr(1, 36'hA_00666564);
        push_ev(0, 2);
        for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), i == 0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send(8'h60 + 8'(i), i == 0, i == 6, 1'b0);
        drain("restart", 2);

        // Fill to commit_ptr=510, then a frame that wraps the address
        do_reset();
        for (int k = 0; k < 510; k++) begin
            fl = (k == 509) ? 4'hE : ((k == 0) ? 4'h1 : 4'h0);
            push_wr(k, {fl, 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        end
        push_ev(0, 510);
        for (int i = 0; i < 2040; i++) begin
            b = 8'(i);
            send(b, i == 0, i == 2039, 1'b0);
        end
        drain("fill", 510);
        bus.rd_ptr = 9'd5;
        push_wr(510, 36'h1_C3C2C1C0);
        push_wr(511, 36'h0_C7C6C5C4);
        push_wr(0, 36'hE_CBCAC9C8);
        push_ev(0, 1);
        for (int i = 0; i < 12; i++) send(8'hC0 + 8'(i), i == 0, i == 11, 1'b0);
        drain("wrap", 1);
        check("wrap_drop_cnt", {48'd0, bus.drop_cnt}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
